// File: rtl/restoring_divider.sv
// Iterative restoring (shift-and-subtract) unsigned divider, one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module restoring_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  v_q, v_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // Trial subtraction for the current iteration; all compares are N+1 bits wide.
  logic [N:0] trial_c;
  logic [N:0] diff_c;
  logic       ge_c;
  logic [N:0] r_next_c;

  assign trial_c  = {r_q[N-1:0], d_q[N-1]};
  assign diff_c   = trial_c - {1'b0, v_q};
  assign ge_c     = (trial_c >= {1'b0, v_q});
  assign r_next_c = ge_c ? diff_c : trial_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            d_d     = dividend;
            v_d     = divisor;
            r_d     = '0;
            quo_d   = '0;
            count_d = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            // Zero divisor skips iteration entirely.
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        r_d     = r_next_c;
        quo_d   = {quo_q[N-2:0], ge_c};
        d_d     = {d_q[N-2:0], 1'b0};
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          rem_d   = r_next_c[N-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table, hand-written corner
// sequences and randomized divisions on N=32 and N=8 instances against an arithmetic model.
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, q32, r32;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic        busy32, done32, dbz32;
  logic        busy8, done8, dbz8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  restoring_divider #(.N(32)) u_div32 (
    .clock(clk), .reset_n(reset_n), .start(start32),
    .dividend(a32), .divisor(b32),
    .quotient(q32), .remainder(r32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  restoring_divider #(.N(8)) u_div8 (
    .clock(clk), .reset_n(reset_n), .start(start8),
    .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if (reset_n)
      check("busy_done_excl", 32'((busy32 & done32) | (busy8 & done8)), 32'd0);
  end

  // Reference: plain integer division on the masked operands.
  task automatic model(input bit w8, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz);
    logic [31:0] mask;
    logic [31:0] am, bm;
    mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    am = a & mask;
    bm = b & mask;
    if (bm == 0) begin
      q = mask; r = am; dbz = 1'b1;
    end else begin
      q = am / bm; r = am % bm; dbz = 1'b0;
    end
  endtask

  task automatic do_div(input bit w8, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input string tag);
    int n;
    int lat;
    int busyc;
    bit got;
    logic [31:0] bm;
    n = w8 ? 8 : 32;
    bm = w8 ? (b & 32'hFF) : b;
    lat = -1;
    busyc = 0;
    got = 1'b0;
    @(negedge clk);
    if (w8) begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin start32 = 1'b1; a32 = a; b32 = b; end
    @(posedge clk);
    #1;
    start8 = 1'b0; start32 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
    for (int k = 0; k <= n + 4; k++) begin
      @(negedge clk);
      if (w8 ? done8 : done32) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (w8 ? busy8 : busy32) busyc++;
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), (bm == 0) ? 32'd0 : 32'(n));
    check({tag, " busy_cycles"}, 32'(busyc), (bm == 0) ? 32'd0 : 32'(n));
    check({tag, " quotient"}, w8 ? {24'd0, q8} : q32, eq);
    check({tag, " remainder"}, w8 ? {24'd0, r8} : r32, er);
    check({tag, " div_by_zero"}, 32'(w8 ? dbz8 : dbz32), 32'(edbz));
    @(negedge clk);
    check({tag, " done_pulse_width"}, 32'(w8 ? done8 : done32), 32'd0);
    check({tag, " quotient_held"}, w8 ? {24'd0, q8} : q32, eq);
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic        edbz;
    int          dones;
    logic [31:0] cap_q, cap_r;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    vecs[4] = '{32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1};
    vecs[5] = '{32'd20, 32'd6, 32'd3, 32'd2, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst quotient", q32, 32'd0);
    check("rst remainder", r32, 32'd0);
    check("rst flags", {29'd0, busy32, done32, dbz32}, 32'd0);
    check("rst8 outputs", {q8, r8, 13'd0, busy8, done8, dbz8}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 7; i++)
      do_div(1'b0, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
             $sformatf("vec%0d", i));

    // Start during RUN is ignored and not queued
    dones = 0;
    cap_q = '0;
    cap_r = '1;
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd1000; b32 = 32'd10;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      start32 = 1'b0;
      if (k == 9) begin start32 = 1'b1; a32 = 32'd50; b32 = 32'd5; end
      if (done32) begin dones++; cap_q = q32; cap_r = r32; end
    end
    start32 = 1'b0;
    check("restart dones", 32'(dones), 32'd1);
    check("restart quotient", cap_q, 32'd100);
    check("restart remainder", cap_r, 32'd0);

    // Reset mid-operation aborts with no done
    @(negedge clk);
    start32 = 1'b1; a32 = 32'd77; b32 = 32'd3;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort quotient", q32, 32'd0);
    check("abort remainder", r32, 32'd0);
    check("abort flags", {29'd0, busy32, done32, dbz32}, 32'd0);
    @(negedge clk);
    check("abort held_in_reset", {29'd0, busy32, done32, dbz32}, 32'd0);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    do_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "after_abort");

    // Randomized divisions on both widths
    for (int i = 0; i < 2000; i++) begin
      bit w8;
      int mode;
      w8 = (i % 2) == 1;
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin a = $urandom; b = 32'd1; end
        1: begin a = $urandom_range(0, 100); b = a + 1 + $urandom_range(0, 150); end
        2: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
        3: begin a = $urandom; b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom; end
        default: begin a = $urandom >> $urandom_range(0, 31); b = $urandom >> $urandom_range(0, 31); end
      endcase
      model(w8, a, b, eq, er, edbz);
      do_div(w8, a, b, eq, er, edbz, w8 ? "rnd8" : "rnd32");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
